mcs4_ram_4002: RTL and testbench

Bus-side responder for one 4002-style RAM chip on the MCS-4 4-bit multiplexed bus: the RAM end of the CPU's SRC/I-O protocol. It tracks the 8-phase instruction cycle (A1,A2,A3,M1,M2,X1,X2,X3) from sync_i and latches SRC addresses and I/O opcodes. It stores 4 registers × 16 main chars plus 4 status chars, drives read data in X2, and owns one 4-bit output port (WMP). One instance is used per chip; four share a bank's cm_ram line.

---
 rtl/mcs4_ram_4002.sv | 200 ++++++++++++++++++++
 tb/tb_mcs4_ram_4002.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mcs4_ram_4002.sv
// mcs4_ram_4002: bus-side responder for one 4002-style RAM chip.
// Follows the 8-phase MCS-4 instruction cycle from sync_i, latches SRC
// addresses and I/O opcodes, holds 4 x (16 main + 4 status) nibbles,
// drives read data during X2 and owns the 4-bit output port.
module mcs4_ram_4002 #(
    parameter logic [1:0] CHIP_ID = 2'd0,
    parameter int         REGS    = 4,
    parameter int         CHARS   = 16,
    parameter int         STATUS  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sync_i,
    input  logic       cm_ram_i,
    input  logic [3:0] data_i,
    output logic [3:0] data_o,
    output logic       data_oe,
    output logic [3:0] port_o
);

    typedef enum logic [2:0] {
        CYC_A1 = 3'd0,
        CYC_A2 = 3'd1,
        CYC_A3 = 3'd2,
        CYC_M1 = 3'd3,
        CYC_M2 = 3'd4,
        CYC_X1 = 3'd5,
        CYC_X2 = 3'd6,
        CYC_X3 = 3'd7
    } cycle_t;

    cycle_t     cycle_r;
    cycle_t     cycle_nxt_s;
    logic       synced_r;
    logic [3:0] opr_r;
    logic [3:0] opa_r;
    logic       io_pend_r;
    logic       selected_r;
    logic       src_hit_r;
    logic [1:0] reg_r;
    logic [3:0] char_r;

    logic [3:0] mem_r  [REGS][CHARS];
    logic [3:0] stat_r [REGS][STATUS];

    // Qualifiers and opcode decode
    logic       live_s;
    logic       exec_x2_s;
    logic       rd_entry_s;
    logic       src_x2_s;
    logic       src_match_s;
    logic       wr_mem_s;
    logic       wr_port_s;
    logic       wr_stat_s;
    logic       rd_hit_s;
    logic [3:0] rd_val_s;

    // Phase sequencing: sync forces A1, otherwise step through the 8 phases
    always_comb begin
        cycle_nxt_s = CYC_A1;
        if (sync_i) begin
            cycle_nxt_s = CYC_A1;
        end else begin
            case (cycle_r)
                CYC_A1:  cycle_nxt_s = CYC_A2;
                CYC_A2:  cycle_nxt_s = CYC_A3;
                CYC_A3:  cycle_nxt_s = CYC_M1;
                CYC_M1:  cycle_nxt_s = CYC_M2;
                CYC_M2:  cycle_nxt_s = CYC_X1;
                CYC_X1:  cycle_nxt_s = CYC_X2;
                CYC_X2:  cycle_nxt_s = CYC_X3;
                CYC_X3:  cycle_nxt_s = CYC_A1;
                default: cycle_nxt_s = CYC_A1;
            endcase
        end
    end

    // Opcode decode and bus qualifiers; a sync_i in the current clk
    // abandons whatever this clk would have committed
    always_comb begin
        wr_mem_s  = 1'b0;
        wr_port_s = 1'b0;
        wr_stat_s = 1'b0;
        rd_hit_s  = 1'b0;
        rd_val_s  = 4'h0;
        case (opa_r)
            4'h0:                      wr_mem_s  = 1'b1;
            4'h1:                      wr_port_s = 1'b1;
            4'h4, 4'h5, 4'h6, 4'h7:    wr_stat_s = 1'b1;
            4'h8, 4'h9, 4'hB: begin
                rd_hit_s = 1'b1;
                rd_val_s = mem_r[reg_r][char_r];
            end
            4'hC, 4'hD, 4'hE, 4'hF: begin
                rd_hit_s = 1'b1;
                rd_val_s = stat_r[reg_r][opa_r[1:0]];
            end
            default: begin
                rd_hit_s = 1'b0;
            end
        endcase
        live_s      = synced_r && !sync_i;
        exec_x2_s   = live_s && (cycle_r == CYC_X2) && io_pend_r && selected_r;
        rd_entry_s  = live_s && (cycle_r == CYC_X1) && io_pend_r && selected_r && rd_hit_s;
        src_x2_s    = live_s && (cycle_r == CYC_X2) && cm_ram_i && !io_pend_r;
        src_match_s = (data_i[3:2] == CHIP_ID);
    end

    // Phase register and sync-seen flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_r  <= CYC_A1;
            synced_r <= 1'b0;
        end else begin
            cycle_r <= cycle_nxt_s;
            if (sync_i) begin
                synced_r <= 1'b1;
            end else begin
                synced_r <= synced_r;
            end
        end
    end

    // OPR/OPA latches and the I/O-pending flag qualified by CM-RAM in M2
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opr_r     <= 4'h0;
            opa_r     <= 4'h0;
            io_pend_r <= 1'b0;
        end else begin
            if (live_s && (cycle_r == CYC_M1)) begin
                opr_r <= data_i;
            end
            if (live_s && (cycle_r == CYC_M2)) begin
                opa_r <= data_i;
            end
            if (sync_i || (cycle_r == CYC_X3)) begin
                io_pend_r <= 1'b0;
            end else if (live_s && (cycle_r == CYC_M2) && cm_ram_i && (opr_r == 4'hE)) begin
                io_pend_r <= 1'b1;
            end
        end
    end

    // SRC address capture: chip/reg in X2, char in X3 only after a match
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            selected_r <= 1'b0;
            src_hit_r  <= 1'b0;
            reg_r      <= 2'd0;
            char_r     <= 4'h0;
        end else if (src_x2_s) begin
            selected_r <= src_match_s;
            src_hit_r  <= src_match_s;
            if (src_match_s) begin
                reg_r <= data_i[1:0];
            end
        end else if (synced_r && (cycle_r == CYC_X3)) begin
            src_hit_r <= 1'b0;
            if (src_hit_r) begin
                char_r <= data_i;
            end
        end else if (sync_i) begin
            src_hit_r <= 1'b0;
        end
    end

    // Storage and output-port writes, committed at the edge ending X2
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_r  <= '{default: '{default: 4'h0}};
            stat_r <= '{default: '{default: 4'h0}};
            port_o <= 4'h0;
        end else if (exec_x2_s) begin
            if (wr_mem_s) begin
                mem_r[reg_r][char_r] <= data_i;
            end
            if (wr_stat_s) begin
                stat_r[reg_r][opa_r[1:0]] <= data_i;
            end
            if (wr_port_s) begin
                port_o <= data_i;
            end
        end
    end

    // Read drive: enable rises entering X2 and falls leaving it; data holds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_o  <= 4'h0;
            data_oe <= 1'b0;
        end else begin
            data_oe <= rd_entry_s;
            if (rd_entry_s) begin
                data_o <= rd_val_s;
            end
        end
    end

endmodule

// File: tb/tb_mcs4_ram_4002.sv
// Testbench for mcs4_ram_4002: directed scenarios followed by random
// instruction streams, compared against an instruction-level model.
module tb_mcs4_ram_4002;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sync_i;
    logic       cm_ram_i;
    logic [3:0] data_i;
    logic [3:0] data_o;
    logic       data_oe;
    logic [3:0] port_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Instruction-level reference state
    logic [3:0] m_mem  [4][16];
    logic [3:0] m_stat [4][4];
    logic [3:0] m_port;
    logic [3:0] m_last;
    bit         m_sel;
    logic [1:0] m_reg;
    logic [3:0] m_char;

    mcs4_ram_4002 #(.CHIP_ID(2'd0)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sync_i   (sync_i),
        .cm_ram_i (cm_ram_i),
        .data_i   (data_i),
        .data_o   (data_o),
        .data_oe  (data_oe),
        .port_o   (port_o)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 16; c++) m_mem[r][c] = 4'h0;
            for (int s = 0; s < 4; s++)  m_stat[r][s] = 4'h0;
        end
        m_port = 4'h0;
        m_last = 4'h0;
        m_sel  = 1'b0;
        m_reg  = 2'd0;
        m_char = 4'h0;
    endtask

    // One-clock SYNC pulse; the following clk is A1
    task automatic sync_pulse();
        @(negedge clk);
        sync_i   = 1'b1;
        cm_ram_i = 1'b0;
        data_i   = 4'h0;
    endtask

    // Runs one instruction, one bus phase per clk. abort_p (0..6) places an
    // extra SYNC in that phase; rst_x2 pulls reset during X2.
    task automatic run_instr(input logic [3:0] opr, input logic [3:0] opa,
                             input bit cm_m2, input bit cm_x2,
                             input logic [3:0] x2d, input logic [3:0] x3d,
                             input int abort_p, input bit rst_x2);
        bit         io;
        bit         rd;
        logic [3:0] rv;
        io = cm_m2 && (opr == 4'hE);
        rd = io && m_sel && (opa inside {4'h8, 4'h9, 4'hB, [4'hC:4'hF]});
        rv = (opa[3:2] == 2'b11) ? m_stat[m_reg][opa[1:0]] : m_mem[m_reg][m_char];
        for (int p = 0; p < 8; p++) begin
            @(negedge clk);
            if (p == 6 && rd) m_last = rv;
            check_val("data_oe", {3'b000, data_oe}, {3'b000, (p == 6 && rd)});
            check_val("data_o", data_o, m_last);
            if (p == 0) check_val("port_o", port_o, m_port);
            if (rst_x2 && p == 6) begin
                rst_n = 1'b0;
                #1;
                check_val("rst_oe", {3'b000, data_oe}, 4'h0);
                check_val("rst_data_o", data_o, 4'h0);
                check_val("rst_port", port_o, 4'h0);
                model_reset();
                sync_i   = 1'b0;
                cm_ram_i = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            case (p)
                3:       data_i = opr;
                4:       data_i = opa;
                6:       data_i = x2d;
                7:       data_i = x3d;
                default: data_i = 4'($urandom());
            endcase
            cm_ram_i = (p == 4 && cm_m2) || (p == 6 && cm_x2);
            sync_i   = (p == 7) || (p == abort_p);
            if (p == abort_p) return;
        end
        if (!io && cm_x2) begin
            m_sel = (x2d[3:2] == 2'd0);
            if (m_sel) begin
                m_reg  = x2d[1:0];
                m_char = x3d;
            end
        end else if (io && m_sel) begin
            case (opa)
                4'h0:                   m_mem[m_reg][m_char] = x2d;
                4'h1:                   m_port = x2d;
                4'h4, 4'h5, 4'h6, 4'h7: m_stat[m_reg][opa[1:0]] = x2d;
                default: ;
            endcase
        end
    endtask

    task automatic src(input logic [3:0] x2d, input logic [3:0] x3d);
        run_instr(4'h2, 4'h1, 1'b0, 1'b1, x2d, x3d, -1, 1'b0);
    endtask

    task automatic io_op(input logic [3:0] opa, input logic [3:0] x2d);
        run_instr(4'hE, opa, 1'b1, 1'b0, x2d, 4'($urandom()), -1, 1'b0);
    endtask

    initial begin
        int kind;
        int ab;
        logic [3:0] x2r;
        rst_n    = 1'b0;
        sync_i   = 1'b0;
        cm_ram_i = 1'b0;
        data_i   = 4'h0;
        model_reset();
        repeat (2) @(negedge clk);
        check_val("reset_oe", {3'b000, data_oe}, 4'h0);
        check_val("reset_data_o", data_o, 4'h0);
        check_val("reset_port", port_o, 4'h0);
        rst_n = 1'b1;

        // Unsynced bus activity must be ignored
        repeat (12) begin
            @(negedge clk);
            check_val("unsynced_oe", {3'b000, data_oe}, 4'h0);
            data_i   = 4'($urandom());
            cm_ram_i = 1'($urandom());
        end

        // Basic write/read at chip0 reg2 char7
        sync_pulse();
        src(4'b0010, 4'h7);
        io_op(4'h0, 4'hA);
        io_op(4'h9, 4'h0);

        // SRC to chip1 deselects: write and read ignored
        src(4'b0100, 4'h7);
        io_op(4'h0, 4'h5);
        io_op(4'h9, 4'h0);
        src(4'b0010, 4'h7);
        io_op(4'h9, 4'h0);

        // Status chars
        src(4'b0001, 4'h0);
        io_op(4'h6, 4'h3);
        io_op(4'hE, 4'h0);
        io_op(4'hD, 4'h0);
        io_op(4'h9, 4'h0);

        // Output port, then WRR/RDR have no effect
        io_op(4'h1, 4'h9);
        io_op(4'h2, 4'h6);
        io_op(4'hA, 4'h0);
        io_op(4'h3, 4'h0);

        // Resync in X1 of a WRM drops the write
        src(4'b0010, 4'h7);
        run_instr(4'hE, 4'h0, 1'b1, 1'b0, 4'h4, 4'h0, 5, 1'b0);
        io_op(4'h9, 4'h0);

        // Reset during X2 of an RDM clears everything
        run_instr(4'hE, 4'h9, 1'b1, 1'b0, 4'h0, 4'h0, -1, 1'b1);
        sync_pulse();
        src(4'b0010, 4'h7);
        io_op(4'h9, 4'h0);

        // Random instruction stream
        for (int i = 0; i < 400; i++) begin
            kind = int'($urandom_range(0, 9));
            ab   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 6)) : -1;
            x2r  = 4'($urandom());
            if (kind <= 2) begin
                if ($urandom_range(0, 3) != 0) x2r[3:2] = 2'd0;
                run_instr(4'h2, 4'($urandom()), 1'b0, 1'b1, x2r, 4'($urandom()), ab, 1'b0);
            end else if (kind <= 7) begin
                run_instr(4'hE, 4'($urandom()), 1'b1, 1'b0, x2r, 4'($urandom()), ab, 1'b0);
            end else begin
                run_instr(4'($urandom_range(0, 13)), 4'($urandom()), 1'($urandom()),
                          1'($urandom()), x2r, 4'($urandom()), ab, 1'b0);
            end
        end

        @(negedge clk);
        check_val("final_port", port_o, m_port);
        check_val("final_oe", {3'b000, data_oe}, 4'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
